// File: rtl/cdc_req_src_if.sv
// Source-side toggle req/ack CDC bundle.
// Upstream valid/ready plus cross-domain req/ack.
interface cdc_req_src_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  req_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_i;
  logic                  done_o;
  logic                  err_o;

  modport master (
    input  valid_i,
    input  dat_i,
    input  ack_i,
    output ready_o,
    output req_o,
    output dat_o,
    output done_o,
    output err_o
  );

  modport slave (
    output valid_i,
    output dat_i,
    output ack_i,
    input  ready_o,
    input  req_o,
    input  dat_o,
    input  done_o,
    input  err_o
  );
endinterface

// File: rtl/cdc_req_src.sv
// Two-phase toggle request source.
// Holds a word on dat_o and toggles req_o per transfer.
module cdc_req_src #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGE      = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  cdc_req_src_if.master   bus
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                state;
  logic [STAGE-1:0]      ack_q;
  logic                  ack_s;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  done_q;
  logic                  err_q;

  // ack_i crosses domains; only the last flop is used
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q <= '0;
    end else begin
      ack_q <= {ack_q[STAGE-2:0], bus.ack_i};
    end
  end

  assign ack_s = ack_q[STAGE-1];

  // Accept in IDLE, wait for the matching ack in WAIT
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= S_IDLE;
      req_q  <= 1'b0;
      dat_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ack_s != req_q) begin
            err_q <= 1'b1;
          end
          if (bus.valid_i) begin
            dat_q <= bus.dat_i;
            req_q <= ~req_q;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_s == req_q) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o = (state == S_IDLE);
  assign bus.req_o   = req_q;
  assign bus.dat_o   = dat_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_cdc_req_src.sv
// Bench for cdc_req_src: vector table, corner
// sequences and randomized traffic against a model.
module tb_cdc_req_src;
  localparam int DW = 32;
  localparam int ST = 2;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          a;
    logic          rdy;
    logic          req;
    logic [DW-1:0] dat;
    logic          done;
    logic          err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdc_req_src_if #(.DATA_WIDTH(DW)) bus ();

  cdc_req_src #(
    .DATA_WIDTH(DW),
    .STAGE(ST)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic          m_busy;
  logic          m_req;
  logic          m_done;
  logic          m_err;
  logic [DW-1:0] m_dat;
  logic          q[$];
  logic          prev_done;

  logic dest_en;
  bit   dest_rand;
  int   dest_dly;
  int   dest_cnt;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_req = 0;
    m_done = 0;
    m_err = 0;
    m_dat = '0;
    prev_done = 0;
    q.delete();
    for (int i = 0; i < ST; i++) q.push_back(1'b0);
  endtask

  // ack seen by the control logic is ack_i as
  // sampled ST edges earlier
  task automatic model_edge();
    logic s;
    s = q.pop_front();
    q.push_back(bus.ack_i);
    m_done = 0;
    if (!m_busy) begin
      if (s != m_req) m_err = 1;
      if (bus.valid_i) begin
        m_dat = bus.dat_i;
        m_req = ~m_req;
        m_busy = 1;
      end
    end else if (s == m_req) begin
      m_busy = 0;
      m_done = 1;
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".ready"}, bus.ready_o, !m_busy);
    chk({tag, ".req"}, bus.req_o, m_req);
    chk({tag, ".dat"}, bus.dat_o, m_dat);
    chk({tag, ".done"}, bus.done_o, m_done);
    chk({tag, ".err"}, bus.err_o, m_err);
    if (prev_done)
      chk({tag, ".done_gap"}, bus.done_o, 0);
    prev_done = bus.done_o;
  endtask

  task automatic dest_step();
    if (dest_en) begin
      if (bus.ack_i != m_req) begin
        if (dest_cnt > 0) dest_cnt--;
        if (dest_cnt == 0) bus.ack_i = m_req;
      end else begin
        dest_cnt = dest_rand ?
          int'($urandom_range(0, 5)) : dest_dly;
      end
    end
  endtask

  task automatic cycle(input string tag,
                       input logic v,
                       input logic [DW-1:0] d);
    bus.valid_i = v;
    bus.dat_i = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_model(tag);
    dest_step();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 0;
    bus.valid_i = 0;
    bus.dat_i = '0;
    bus.ack_i = 0;
    #1;
    chk({tag, ".rst_req"}, bus.req_o, 0);
    chk({tag, ".rst_dat"}, bus.dat_o, 0);
    chk({tag, ".rst_ready"}, bus.ready_o, 1);
    chk({tag, ".rst_done"}, bus.done_o, 0);
    chk({tag, ".rst_err"}, bus.err_o, 0);
    model_reset();
    dest_cnt = dest_dly;
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic vec_t mk(
    logic v, logic [DW-1:0] d, logic a,
    logic rdy, logic req, logic [DW-1:0] dat,
    logic done, logic err);
    vec_t r;
    r.v = v; r.d = d; r.a = a;
    r.rdy = rdy; r.req = req; r.dat = dat;
    r.done = done; r.err = err;
    return r;
  endfunction

  initial begin
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;
    logic          exp_req[3];
    logic          was_ready;
    logic          was_done;
    logic [DW-1:0] word;
    int            acc;
    logic          seen;

    bus.valid_i = 0;
    bus.dat_i = '0;
    bus.ack_i = 0;
    dest_en = 0;
    dest_rand = 0;
    dest_dly = 3;
    dest_cnt = 3;
    model_reset();

    w1 = 32'hA5A5_0001;
    w2 = 32'h1234_5678;
    tbl.push_back(mk(1, w1, 0, 0, 1, w1, 0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(logic'(i % 2), 32'hDEAD_BEEF,
                       0, 0, 1, w1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, w1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, w1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, w1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, w1, 0, 0));
    tbl.push_back(mk(1, w2, 1, 0, 0, w2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, w2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, w2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, w2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, w2, 0, 0));

    do_reset("init");
    foreach (tbl[i]) begin
      bus.valid_i = tbl[i].v;
      bus.dat_i = tbl[i].d;
      bus.ack_i = tbl[i].a;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk($sformatf("vec%0d.ready", i),
          bus.ready_o, tbl[i].rdy);
      chk($sformatf("vec%0d.req", i),
          bus.req_o, tbl[i].req);
      chk($sformatf("vec%0d.dat", i),
          bus.dat_o, tbl[i].dat);
      chk($sformatf("vec%0d.done", i),
          bus.done_o, tbl[i].done);
      chk($sformatf("vec%0d.err", i),
          bus.err_o, tbl[i].err);
    end

    do_reset("b2b");
    dest_en = 1;
    dest_rand = 0;
    dest_dly = 3;
    dest_cnt = 3;
    exp_req[0] = 1;
    exp_req[1] = 0;
    exp_req[2] = 1;
    word = 1;
    acc = 0;
    for (int n = 0; n < 60 && acc < 3; n++) begin
      was_ready = !m_busy;
      was_done = bus.done_o;
      cycle("b2b", 1, word);
      if (was_ready) begin
        chk($sformatf("b2b.req%0d", acc),
            bus.req_o, exp_req[acc]);
        chk($sformatf("b2b.word%0d", acc),
            bus.dat_o, word);
        if (acc > 0)
          chk($sformatf("b2b.done_at_acc%0d", acc),
              was_done, 1);
        acc++;
        word++;
      end
    end
    chk("b2b.count", acc, 3);
    for (int n = 0; n < 12; n++) cycle("b2b_drain", 0, 0);

    do_reset("spur");
    dest_en = 0;
    cycle("spur", 0, 0);
    bus.ack_i = 1;
    cycle("spur", 0, 0);
    bus.ack_i = 0;
    for (int n = 0; n < 6; n++) cycle("spur", 0, 0);
    chk("spur.err_sticky", bus.err_o, 1);
    chk("spur.ready", bus.ready_o, 1);

    do_reset("mid");
    dest_en = 1;
    dest_dly = 4;
    dest_cnt = 4;
    cycle("mid", 1, 32'hCAFE_0001);
    cycle("mid", 0, 0);
    cycle("mid", 0, 0);
    do_reset("mid_rst");
    cycle("mid2", 1, 32'h0BAD_F00D);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cycle("mid2", 0, 0);
      if (bus.done_o) seen = 1;
    end
    chk("mid2.done_seen", seen, 1);

    do_reset("rnd");
    dest_en = 1;
    dest_rand = 1;
    for (int n = 0; n < 2000; n++)
      cycle("rnd", logic'($urandom_range(0, 1)), $urandom);
    for (int n = 0; n < 12; n++) cycle("rnd_drain", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
